// File: rtl/quadgen_pkg.sv
// Shared types for the quadrature generator: FSM states, the {a,b} phase and
// the Gray-code stepping function.
package quadgen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DWELL
    } state_t;

    // Bit 1 is channel A, bit 0 is channel B.
    typedef logic [1:0] phase_t;

    // One quadrature edge: CW walks 00->10->11->01->00, CCW walks it backwards.
    function automatic phase_t next_phase(input phase_t p, input logic ccw);
        phase_t n;
        case (p)
            2'b00:   n = ccw ? 2'b01 : 2'b10;
            2'b10:   n = ccw ? 2'b00 : 2'b11;
            2'b11:   n = ccw ? 2'b10 : 2'b01;
            default: n = ccw ? 2'b11 : 2'b00;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/quadgen_step_accum.sv
// Saturating signed pending-step counter: requests in, completed steps out,
// with a one-cycle overflow pulse for every request it has to drop.
module step_accum #(
    parameter int PEND_W = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cw_i,
    input  logic                     ccw_i,
    input  logic                     done_i,
    input  logic                     dir_i,
    output logic signed [PEND_W-1:0] pending_o,
    output logic signed [PEND_W-1:0] pending_nxt_o,
    output logic                     overflow_o
);
    localparam int LIM    = (1 << (PEND_W - 1)) - 1;
    localparam int REP_LO = -(1 << (PEND_W - 1));

    logic signed [PEND_W-1:0] pending_q, pending_d;
    logic                     overflow_q, overflow_d;
    int                       req, cmp, want, nxt;

    always_comb begin
        req = 0;
        if (cw_i && !ccw_i) begin
            req = 1;
        end else if (ccw_i && !cw_i) begin
            req = -1;
        end
        cmp = 0;
        if (done_i) begin
            cmp = dir_i ? 1 : -1;
        end
        want       = int'(pending_q) + req;
        overflow_d = (req != 0) && ((want > LIM) || (want < -LIM));
        nxt        = (overflow_d ? int'(pending_q) : want) + cmp;
        // A completion racing a saturated reverse backlog must not wrap.
        if (nxt > LIM) begin
            nxt = LIM;
        end
        if (nxt < REP_LO) begin
            nxt = REP_LO;
        end
        pending_d = nxt[PEND_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign pending_o     = pending_q;
    assign pending_nxt_o = pending_d;
    assign overflow_o    = overflow_q;

endmodule

// File: rtl/quadgen.sv
// Quadrature waveform generator: replays accumulated cw/ccw step requests on
// a/b as legal Gray-coded phases, DWELL cycles per phase.
module quadgen
    import quadgen_pkg::*;
#(
    parameter int DWELL          = 50000,
    parameter int EDGES_PER_STEP = 4,
    parameter int PEND_W         = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cw,
    input  logic                     ccw,
    output logic                     a,
    output logic                     b,
    output logic                     busy,
    output logic signed [PEND_W-1:0] pending,
    output logic                     overflow
);
    localparam int            TW     = $clog2(DWELL);
    localparam int            EW     = $clog2(EDGES_PER_STEP) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(DWELL - 1);
    localparam logic [EW-1:0] E_LAST = EW'(EDGES_PER_STEP - 1);

    state_t                   state_q, state_d;
    logic [TW-1:0]            timer_q, timer_d;
    logic [EW-1:0]            edges_q, edges_d;
    phase_t                   phase_q, phase_d;
    logic                     dir_q, dir_d;   // 1 = CCW
    logic                     step_done;
    logic signed [PEND_W-1:0] pending_nxt;

    step_accum #(.PEND_W(PEND_W)) u_accum (
        .clk          (clk),
        .reset_n      (reset_n),
        .cw_i         (cw),
        .ccw_i        (ccw),
        .done_i       (step_done),
        .dir_i        (dir_q),
        .pending_o    (pending),
        .pending_nxt_o(pending_nxt),
        .overflow_o   (overflow)
    );

    assign step_done = (state_q == ST_DWELL) && (timer_q == T_LAST) && (edges_q == E_LAST);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        edges_d = edges_q;
        phase_d = phase_q;
        dir_d   = dir_q;
        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                edges_d = '0;
                if (pending != '0) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                dir_d   = pending[PEND_W-1];
                edges_d = '0;
                // The RUN cycle is tick 0 of the first dwell.
                if (pending == '0) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else begin
                    state_d = ST_DWELL;
                    timer_d = TW'(1);
                end
            end
            ST_DWELL: begin
                if (timer_q == T_LAST) begin
                    timer_d = '0;
                    phase_d = next_phase(phase_q, dir_q);
                    if (step_done) begin
                        edges_d = '0;
                        if (pending_nxt == '0) begin
                            state_d = ST_IDLE;
                        end else begin
                            dir_d = pending_nxt[PEND_W-1];
                        end
                    end else begin
                        edges_d = edges_q + 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            edges_q <= '0;
            phase_q <= 2'b00;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            edges_q <= edges_d;
            phase_q <= phase_d;
            dir_q   <= dir_d;
        end
    end

    assign a    = phase_q[1];
    assign b    = phase_q[0];
    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_quadgen.sv
// Bench for quadgen: directed scenarios plus random request traffic, checked
// every cycle against a position/elapsed-time reference model.
module tb_quadgen;
    localparam int DW   = 4;
    localparam int EPS  = 4;
    localparam int PW   = 4;
    localparam int PMAX = (1 << (PW - 1)) - 1;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 cw = 1'b0;
    logic                 ccw = 1'b0;
    logic                 a, b, busy, overflow;
    logic signed [PW-1:0] pending;

    quadgen #(.DWELL(DW), .EDGES_PER_STEP(EPS), .PEND_W(PW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cw      (cw),
        .ccw     (ccw),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .pending (pending),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // Model: signed position along the CW Gray cycle, elapsed cycles in step.
    int m_pend = 0, m_pos = 0, m_dir = 1, m_el = 0;
    bit m_busy = 1'b0, m_latch = 1'b0, m_ovf = 1'b0;
    logic [1:0] ph_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    logic [1:0] prev_ab = 2'b00;
    int         edge_cyc[$];
    logic [1:0] edge_ph[$];
    int         busy_cnt = 0, ovf_cnt = 0, pend_min = 0;
    int         tr;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_step(input bit c, input bit cc, input bit rn);
        int req, comp, want, np, n_el, n_dir, n_pos;
        bit n_busy, n_latch, fin, drop;
        if (!rn) begin
            m_pend = 0; m_pos = 0; m_dir = 1; m_el = 0;
            m_busy = 0; m_latch = 0; m_ovf = 0;
            return;
        end
        req = (c && !cc) ? 1 : ((cc && !c) ? -1 : 0);
        comp = 0; fin = 0;
        n_busy = m_busy; n_latch = 0; n_el = m_el; n_dir = m_dir; n_pos = m_pos;
        if (!m_busy) begin
            if (m_pend != 0) begin
                n_busy = 1; n_latch = 1; n_el = 0;
            end
        end else if (m_latch) begin
            if (m_pend == 0) n_busy = 0;
            else begin
                n_dir = (m_pend < 0) ? -1 : 1;
                n_el  = 1;
            end
        end else begin
            n_el = m_el + 1;
            if (n_el % DW == 0) n_pos = m_pos + m_dir;
            if (n_el == EPS * DW) begin
                fin = 1; comp = -m_dir; n_el = 0;
            end
        end
        want = m_pend + req;
        drop = (req != 0) && (want > PMAX || want < -PMAX);
        np   = (drop ? m_pend : want) + comp;
        if (np > PMAX) np = PMAX;
        if (np < -PMAX - 1) np = -PMAX - 1;
        if (fin) begin
            if (np == 0) n_busy = 0;
            else n_dir = (np < 0) ? -1 : 1;
        end
        m_pend = np; m_pos = n_pos; m_dir = n_dir; m_el = n_el;
        m_busy = n_busy; m_latch = n_latch; m_ovf = drop;
    endtask

    task automatic tick(input bit c, input bit cc, input bit rn);
        logic [1:0] e;
        cw = c; ccw = cc; reset_n = rn;
        @(posedge clk);
        model_step(c, cc, rn);
        #1;
        cyc++;
        e = ph_tab[((m_pos % 4) + 4) % 4];
        chk("a", a, e[1]);
        chk("b", b, e[0]);
        chk("busy", busy, m_busy);
        chk("pending", pending, m_pend);
        chk("overflow", overflow, m_ovf);
        if ({a, b} !== prev_ab) begin
            edge_cyc.push_back(cyc);
            edge_ph.push_back({a, b});
            prev_ab = {a, b};
        end
        if (busy === 1'b1) busy_cnt++;
        if (overflow === 1'b1) ovf_cnt++;
        if (pending < pend_min) pend_min = pending;
        cw = 1'b0; ccw = 1'b0; reset_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0, 1'b1);
    endtask

    task automatic clear_stats();
        edge_cyc.delete();
        edge_ph.delete();
        busy_cnt = 0; ovf_cnt = 0; pend_min = 0;
        prev_ab = {a, b};
    endtask

    initial begin
        logic [1:0] cw_seq [4]  = '{2'b10, 2'b11, 2'b01, 2'b00};
        logic [1:0] rev_seq [8] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00};

        // Reset state
        tick(0, 0, 0);
        tick(0, 0, 0);
        chk("rst_a", a, 0);
        chk("rst_b", b, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pending", pending, 0);
        chk("rst_overflow", overflow, 0);

        // Single CW step
        clear_stats();
        tr = cyc;
        tick(1, 0, 1);
        chk("s1_pend_req", pending, 1);
        idle(24);
        chk("s1_nedges", edge_cyc.size(), 4);
        chk("s1_first_edge", edge_cyc[0] - tr, 6);
        chk("s1_span", edge_cyc[3] - edge_cyc[0], 3 * DW);
        for (int k = 0; k < 4; k++) chk("s1_phase", edge_ph[k], cw_seq[k]);
        chk("s1_busy_cycles", busy_cnt, 16);
        chk("s1_pend_end", pending, 0);

        // 3 CW then 2 CCW inside the first step
        clear_stats();
        tick(1, 0, 1); chk("s2_p1", pending, 1);
        tick(1, 0, 1); chk("s2_p2", pending, 2);
        tick(1, 0, 1); chk("s2_p3", pending, 3);
        tick(0, 1, 1); chk("s2_p4", pending, 2);
        tick(0, 1, 1); chk("s2_p5", pending, 1);
        idle(30);
        chk("s2_nedges", edge_cyc.size(), 4);
        chk("s2_last_phase", {a, b}, 2'b00);
        chk("s2_busy_end", busy, 0);
        chk("s2_pend_end", pending, 0);

        // Simultaneous cw and ccw cancel
        clear_stats();
        tick(1, 1, 1);
        chk("s3_pend", pending, 0);
        chk("s3_ovf", overflow, 0);
        idle(10);
        chk("s3_nedges", edge_cyc.size(), 0);
        chk("s3_busy_cycles", busy_cnt, 0);
        chk("s3_ovf_cnt", ovf_cnt, 0);

        // Saturation: 8 CW requests, 7 accepted
        clear_stats();
        repeat (8) tick(1, 0, 1);
        chk("s4_pend_sat", pending, 7);
        chk("s4_ovf_pulse", overflow, 1);
        idle(125);
        chk("s4_ovf_cnt", ovf_cnt, 1);
        chk("s4_nedges", edge_cyc.size(), 28);
        chk("s4_pend_end", pending, 0);
        chk("s4_busy_end", busy, 0);

        // Reversal during an in-flight CW step
        clear_stats();
        tick(1, 0, 1);
        idle(7);
        tick(0, 1, 1);
        idle(40);
        chk("s5_nedges", edge_cyc.size(), 8);
        for (int k = 0; k < 8; k++) chk("s5_phase", edge_ph[k], rev_seq[k]);
        chk("s5_pend_min", pend_min, -1);
        chk("s5_pend_end", pending, 0);

        // Reset mid-dwell at phase 11
        clear_stats();
        tick(1, 0, 1);
        for (int i = 0; i < 40 && ({a, b} !== 2'b11); i++) tick(0, 0, 1);
        chk("s6_reached_11", {a, b}, 2'b11);
        idle(1);
        tick(0, 0, 0);
        chk("s6_ab", {a, b}, 2'b00);
        chk("s6_busy", busy, 0);
        chk("s6_pend", pending, 0);
        clear_stats();
        idle(20);
        chk("s6_nedges", edge_cyc.size(), 0);
        chk("s6_busy_cycles", busy_cnt, 0);

        // Random traffic against the model
        repeat (400) tick($urandom_range(9) == 0, $urandom_range(9) == 0, $urandom_range(149) != 0);
        idle(200);
        chk("rnd_pend_end", pending, 0);
        chk("rnd_busy_end", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
